// File: rtl/clken_divbank.sv
// clken_divbank: bank of CHANNELS clock-enable generators on a single clock.
// Each channel emits a one-cycle ce pulse every D+1 cycles plus a divided
// square wave (phase). Ratio/run changes to a running channel are held as
// pending and applied only at terminal count, so enables never glitch.
// Optional feature macro: CLKEN_DIVBANK_ALIGN_EN adds the 'align' input that
// restarts every running channel phase-aligned.
module clken_divbank #(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 8,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef CLKEN_DIVBANK_ALIGN_EN
    input  logic                align,
`endif
    input  logic                cfg_we,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                cfg_inv,
    input  logic                cfg_run,
    output logic [CHANNELS-1:0] ce,
    output logic [CHANNELS-1:0] phase,
    output logic [CHANNELS-1:0] pend
);

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'b00,
        ST_RUN      = 2'b01,
        ST_RUN_PEND = 2'b10
    } ch_state_e;

    // Registered per-channel state
    ch_state_e           r_state [CHANNELS];
    logic [DIV_W-1:0]    r_cnt   [CHANNELS];
    logic [DIV_W-1:0]    r_div   [CHANNELS];
    logic [DIV_W-1:0]    r_pdiv  [CHANNELS];
    logic [CHANNELS-1:0] r_inv;
    logic [CHANNELS-1:0] r_tog;
    logic [CHANNELS-1:0] r_prun;
    logic [CHANNELS-1:0] r_ce;
    logic [CHANNELS-1:0] r_phase;
    logic [CHANNELS-1:0] r_pend;

    // Next-state values
    ch_state_e           w_state [CHANNELS];
    logic [DIV_W-1:0]    w_cnt   [CHANNELS];
    logic [DIV_W-1:0]    w_div   [CHANNELS];
    logic [DIV_W-1:0]    w_pdiv  [CHANNELS];
    logic [DIV_W-1:0]    w_eff_div [CHANNELS];
    logic [CHANNELS-1:0] w_eff_run;
    logic [CHANNELS-1:0] w_inv;
    logic [CHANNELS-1:0] w_tog;
    logic [CHANNELS-1:0] w_prun;
    logic [CHANNELS-1:0] w_ce;
    logic [CHANNELS-1:0] w_hit;
    logic                w_align;

`ifdef CLKEN_DIVBANK_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    // Decode which channel a config write targets; out-of-range selects hit nothing
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_hit[i] = cfg_we && (cfg_ch == CH_W'(i));
        end
    end

    // Configuration that becomes active once any pending write is applied
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_state[i] == ST_RUN_PEND) begin
                w_eff_div[i] = r_pdiv[i];
                w_eff_run[i] = r_prun[i];
            end else begin
                w_eff_div[i] = r_div[i];
                w_eff_run[i] = 1'b1;
            end
        end
    end

    // Per-channel next-state: counting, terminal-count reload, config writes, align
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            w_state[i] = r_state[i];
            w_cnt[i]   = r_cnt[i];
            w_div[i]   = r_div[i];
            w_pdiv[i]  = r_pdiv[i];
            w_inv[i]   = r_inv[i];
            w_tog[i]   = r_tog[i];
            w_prun[i]  = r_prun[i];
            w_ce[i]    = 1'b0;
            case (r_state[i])
                ST_STOPPED: begin
                    if (w_hit[i]) begin
                        w_div[i]   = cfg_div;
                        w_cnt[i]   = cfg_div;
                        w_inv[i]   = cfg_inv;
                        w_tog[i]   = 1'b0;
                        w_state[i] = cfg_run ? ST_RUN : ST_STOPPED;
                    end else begin
                        w_ce[i] = 1'b0;
                    end
                end
                ST_RUN, ST_RUN_PEND: begin
                    if (w_align) begin
                        // Restart from the active divider with toggle cleared, no pulse
                        w_div[i]   = w_eff_div[i];
                        w_cnt[i]   = w_eff_run[i] ? w_eff_div[i] : {DIV_W{1'b0}};
                        w_tog[i]   = 1'b0;
                        w_state[i] = w_eff_run[i] ? ST_RUN : ST_STOPPED;
                        if (w_hit[i] && w_eff_run[i]) begin
                            w_inv[i]   = cfg_inv;
                            w_pdiv[i]  = cfg_div;
                            w_prun[i]  = cfg_run;
                            w_state[i] = ST_RUN_PEND;
                        end else if (w_hit[i]) begin
                            // Align just stopped the channel: take the write directly
                            w_div[i]   = cfg_div;
                            w_cnt[i]   = cfg_div;
                            w_inv[i]   = cfg_inv;
                            w_state[i] = cfg_run ? ST_RUN : ST_STOPPED;
                        end else begin
                            w_ce[i] = 1'b0;
                        end
                    end else if (r_cnt[i] == {DIV_W{1'b0}}) begin
                        // Terminal count: pulse, toggle and reload
                        w_ce[i]  = 1'b1;
                        w_tog[i] = ~r_tog[i];
                        if (w_hit[i]) begin
                            // A write on this edge becomes the reload value directly
                            w_inv[i]   = cfg_inv;
                            w_div[i]   = cfg_div;
                            w_cnt[i]   = cfg_run ? cfg_div : {DIV_W{1'b0}};
                            w_state[i] = cfg_run ? ST_RUN : ST_STOPPED;
                        end else begin
                            w_div[i]   = w_eff_div[i];
                            w_cnt[i]   = w_eff_run[i] ? w_eff_div[i] : {DIV_W{1'b0}};
                            w_state[i] = w_eff_run[i] ? ST_RUN : ST_STOPPED;
                        end
                    end else begin
                        w_cnt[i] = r_cnt[i] - {{(DIV_W-1){1'b0}}, 1'b1};
                        if (w_hit[i]) begin
                            // Mid-count: inversion is immediate, ratio/run wait
                            w_inv[i]   = cfg_inv;
                            w_pdiv[i]  = cfg_div;
                            w_prun[i]  = cfg_run;
                            w_state[i] = ST_RUN_PEND;
                        end else begin
                            w_ce[i] = 1'b0;
                        end
                    end
                end
                default: begin
                    w_state[i] = ST_STOPPED;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= ST_STOPPED;
                r_cnt[i]   <= {DIV_W{1'b0}};
                r_div[i]   <= {DIV_W{1'b0}};
                r_pdiv[i]  <= {DIV_W{1'b0}};
            end
            r_inv   <= {CHANNELS{1'b0}};
            r_tog   <= {CHANNELS{1'b0}};
            r_prun  <= {CHANNELS{1'b0}};
            r_ce    <= {CHANNELS{1'b0}};
            r_phase <= {CHANNELS{1'b0}};
            r_pend  <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_state[i] <= w_state[i];
                r_cnt[i]   <= w_cnt[i];
                r_div[i]   <= w_div[i];
                r_pdiv[i]  <= w_pdiv[i];
                r_pend[i]  <= (w_state[i] == ST_RUN_PEND);
            end
            r_inv   <= w_inv;
            r_tog   <= w_tog;
            r_prun  <= w_prun;
            r_ce    <= w_ce;
            r_phase <= w_tog ^ w_inv;
        end
    end

    assign ce    = r_ce;
    assign phase = r_phase;
    assign pend  = r_pend;

endmodule

// File: tb/tb_clken_divbank.sv
// Directed self-checking bench for clken_divbank (CHANNELS=4, DIV_W=8).
module tb_clken_divbank;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       align = 1'b0;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_ch = 2'd0;
    logic [7:0] cfg_div = 8'd0;
    logic       cfg_inv = 1'b0;
    logic       cfg_run = 1'b0;
    logic [3:0] ce;
    logic [3:0] phase;
    logic [3:0] pend;

    int n_cmp = 0;
    int n_bad = 0;

    clken_divbank dut (
        .clk     (clk),
        .rst     (rst),
`ifdef CLKEN_DIVBANK_ALIGN_EN
        .align   (align),
`endif
        .cfg_we  (cfg_we),
        .cfg_ch  (cfg_ch),
        .cfg_div (cfg_div),
        .cfg_inv (cfg_inv),
        .cfg_run (cfg_run),
        .ce      (ce),
        .phase   (phase),
        .pend    (pend)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [7:0] d, input logic inv, input logic run);
        cfg_we = 1'b1; cfg_ch = ch; cfg_div = d; cfg_inv = inv; cfg_run = run;
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ce !== 4'b0000) begin n_bad++; $display("FAIL reset_ce got %b exp 0000", ce); end
        n_cmp++; if (phase !== 4'b0000) begin n_bad++; $display("FAIL reset_phase got %b exp 0000", phase); end
        n_cmp++; if (pend !== 4'b0000) begin n_bad++; $display("FAIL reset_pend got %b exp 0000", pend); end
    endtask

    task automatic test_basic_div();
        logic e_ce, e_ph;
        do_reset();
        wr(2'd0, 8'd3, 1'b0, 1'b1);
        for (int k = 1; k <= 16; k++) begin
            cyc();
            e_ce = (k % 4 == 0);
            e_ph = ((k / 4) % 2 == 1);
            n_cmp++; if (ce[0] !== e_ce) begin n_bad++; $display("FAIL div3_ce k=%0d got %b exp %b", k, ce[0], e_ce); end
            n_cmp++; if (phase[0] !== e_ph) begin n_bad++; $display("FAIL div3_phase k=%0d got %b exp %b", k, phase[0], e_ph); end
            n_cmp++; if (ce[3:1] !== 3'b000) begin n_bad++; $display("FAIL div3_others k=%0d got %b exp 000", k, ce[3:1]); end
        end
    endtask

    task automatic test_pending();
        logic e_ce;
        do_reset();
        wr(2'd1, 8'd1, 1'b0, 1'b1);
        cyc();
        n_cmp++; if (ce[1] !== 1'b0) begin n_bad++; $display("FAIL pend_pre_ce got %b exp 0", ce[1]); end
        cyc();
        n_cmp++; if (ce[1] !== 1'b1) begin n_bad++; $display("FAIL pend_first_ce got %b exp 1", ce[1]); end
        wr(2'd1, 8'd4, 1'b0, 1'b1);
        n_cmp++; if (pend[1] !== 1'b1) begin n_bad++; $display("FAIL pend_set got %b exp 1", pend[1]); end
        n_cmp++; if (ce[1] !== 1'b0) begin n_bad++; $display("FAIL pend_mid_ce got %b exp 0", ce[1]); end
        cyc();
        n_cmp++; if (ce[1] !== 1'b1) begin n_bad++; $display("FAIL pend_old_spacing got %b exp 1", ce[1]); end
        n_cmp++; if (pend[1] !== 1'b0) begin n_bad++; $display("FAIL pend_clear got %b exp 0", pend[1]); end
        for (int k = 1; k <= 10; k++) begin
            cyc();
            e_ce = (k % 5 == 0);
            n_cmp++; if (ce[1] !== e_ce) begin n_bad++; $display("FAIL pend_new_ce k=%0d got %b exp %b", k, ce[1], e_ce); end
            n_cmp++; if (pend[1] !== 1'b0) begin n_bad++; $display("FAIL pend_stays0 k=%0d got %b exp 0", k, pend[1]); end
        end
    endtask

    task automatic test_stop();
        do_reset();
        wr(2'd2, 8'd2, 1'b0, 1'b1);
        cyc();
        cyc();
        cyc();
        n_cmp++; if ({ce[2], phase[2]} !== 2'b11) begin n_bad++; $display("FAIL stop_first got ce/ph %b%b exp 11", ce[2], phase[2]); end
        wr(2'd2, 8'd2, 1'b0, 1'b0);
        n_cmp++; if (pend[2] !== 1'b1) begin n_bad++; $display("FAIL stop_pend got %b exp 1", pend[2]); end
        cyc();
        n_cmp++; if (ce[2] !== 1'b0) begin n_bad++; $display("FAIL stop_mid_ce got %b exp 0", ce[2]); end
        cyc();
        n_cmp++; if (ce[2] !== 1'b1) begin n_bad++; $display("FAIL stop_last_ce got %b exp 1", ce[2]); end
        n_cmp++; if (pend[2] !== 1'b0) begin n_bad++; $display("FAIL stop_pend_clr got %b exp 0", pend[2]); end
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_cmp++; if ({ce[2], phase[2]} !== 2'b00) begin n_bad++; $display("FAIL stop_frozen k=%0d got ce/ph %b%b exp 00", k, ce[2], phase[2]); end
        end
        wr(2'd2, 8'd2, 1'b1, 1'b0);
        n_cmp++; if (phase[2] !== 1'b1) begin n_bad++; $display("FAIL stop_inv got %b exp 1", phase[2]); end
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_cmp++; if ({ce[2], phase[2]} !== 2'b01) begin n_bad++; $display("FAIL stop_inv_hold k=%0d got ce/ph %b%b exp 01", k, ce[2], phase[2]); end
        end
    endtask

    task automatic test_tc_write();
        logic e_ph;
        do_reset();
        wr(2'd3, 8'd2, 1'b0, 1'b1);
        cyc();
        cyc();
        wr(2'd3, 8'd0, 1'b0, 1'b1);
        n_cmp++; if (ce[3] !== 1'b1) begin n_bad++; $display("FAIL tc_ce got %b exp 1", ce[3]); end
        n_cmp++; if (pend[3] !== 1'b0) begin n_bad++; $display("FAIL tc_pend got %b exp 0", pend[3]); end
        for (int k = 1; k <= 6; k++) begin
            cyc();
            e_ph = (k % 2 == 0);
            n_cmp++; if (ce[3] !== 1'b1) begin n_bad++; $display("FAIL tc_every k=%0d got %b exp 1", k, ce[3]); end
            n_cmp++; if (pend[3] !== 1'b0) begin n_bad++; $display("FAIL tc_pend k=%0d got %b exp 0", k, pend[3]); end
            n_cmp++; if (phase[3] !== e_ph) begin n_bad++; $display("FAIL tc_phase k=%0d got %b exp %b", k, phase[3], e_ph); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        wr(2'd3, 8'd3, 1'b0, 1'b1);
        wr(2'd0, 8'd0, 1'b0, 1'b1);
        wr(2'd1, 8'd1, 1'b0, 1'b1);
        wr(2'd2, 8'd2, 1'b0, 1'b1);
        cyc();
        wr(2'd3, 8'd7, 1'b1, 1'b1);
        n_cmp++; if (pend[3] !== 1'b1) begin n_bad++; $display("FAIL rmid_pend_pre got %b exp 1", pend[3]); end
        n_cmp++; if (ce[0] !== 1'b1) begin n_bad++; $display("FAIL rmid_run_pre got %b exp 1", ce[0]); end
        rst = 1'b1;
        cfg_we = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; cfg_inv = 1'b1; cfg_run = 1'b1;
        cyc();
        rst = 1'b0;
        cfg_we = 1'b0;
        n_cmp++; if ({ce, phase, pend} !== 12'h000) begin n_bad++; $display("FAIL rmid_after got ce=%b ph=%b pend=%b exp all 0", ce, phase, pend); end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            n_cmp++; if ({ce, phase, pend} !== 12'h000) begin n_bad++; $display("FAIL rmid_quiet k=%0d got ce=%b ph=%b pend=%b exp all 0", k, ce, phase, pend); end
        end
    endtask

`ifdef CLKEN_DIVBANK_ALIGN_EN
    task automatic test_align();
        logic [1:0] e_ce;
        do_reset();
        wr(2'd0, 8'd2, 1'b0, 1'b1);
        cyc();
        wr(2'd1, 8'd5, 1'b0, 1'b1);
        cyc();
        cyc();
        cyc();
        align = 1'b1;
        cyc();
        align = 1'b0;
        n_cmp++; if (ce[1:0] !== 2'b00) begin n_bad++; $display("FAIL align_noce got %b exp 00", ce[1:0]); end
        n_cmp++; if (phase[1:0] !== 2'b00) begin n_bad++; $display("FAIL align_phase got %b exp 00", phase[1:0]); end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            e_ce = {(k % 6 == 0), (k % 3 == 0)};
            n_cmp++; if (ce[1:0] !== e_ce) begin n_bad++; $display("FAIL align_ce k=%0d got %b exp %b", k, ce[1:0], e_ce); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_div();
        test_pending();
        test_stop();
        test_tc_write();
        test_reset_mid();
`ifdef CLKEN_DIVBANK_ALIGN_EN
        test_align();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/clken_divbank.md
Name: clken_divbank

Overview:
- Parametrised bank of clock-enable generators for clock-buffer-mapped designs.
- Replaces ad-hoc derived clocks with single-cycle enables on the primary clock, for enable-flop sinks.
- Each channel has a programmable divide ratio, optional output inversion and run/stop control.
- Ratio and stop changes take effect only at the channel's terminal count, so enables never glitch.

Parameters:
- CHANNELS, 4, number of independent enable channels (1..16).
- DIV_W, 8, width of the divide-ratio field.
- CH_W, $clog2(CHANNELS) with a minimum of 1, width of the channel select.

Ports:
- clk  input  1  sole clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  configuration write strobe, one cycle.
- cfg_ch  input  CH_W  target channel of the write.
- cfg_div  input  DIV_W  divide value D; the channel pulses every D+1 cycles.
- cfg_inv  input  1  invert that channel's phase output.
- cfg_run  input  1  1 = run, 0 = stop.
- ce  output  CHANNELS  registered single-cycle enable pulse per channel.
- phase  output  CHANNELS  registered divided square wave per channel (toggles on each ce), XOR inv.
- pend  output  CHANNELS  1 while a pending config waits for terminal count.

Behaviour:
- Reset applies at any edge with rst=1, including mid-operation. Every channel is cleared: cnt=0, div=0, run=0, inv=0, toggle=0, pending=0. Outputs after reset: ce=0, phase=0, pend=0. rst overrides cfg_we in the same cycle.
- Per-channel state: cnt[DIV_W], div[DIV_W], run, inv, toggle, plus pend_div, pend_run, pending.
- Channel states:
  - STOPPED: run=0.
  - RUNNING: run=1, pending=0.
  - RUNNING_PEND: run=1, pending=1.
- Write to a STOPPED channel (cfg_we at edge t):
  - div, inv and run load immediately; cnt loads D; toggle is cleared.
  - If cfg_run=1, the first ce goes high after edge t+1+D. Pulses then repeat every D+1 cycles.
  - D=0 gives ce high every cycle.
- Write to a RUNNING channel:
  - inv updates immediately.
  - D and run are captured into pend_div/pend_run; pending is set, and so is pend.
  - A second write before the terminal count overwrites the pending values.
- Running channel, each edge:
  - If cnt!=0: cnt decrements and ce=0.
  - If cnt==0 (terminal count): ce=1 next cycle and toggle flips.
  - At terminal count, if pending is set: div=pend_div, run=pend_run, pending clears, and cnt reloads from the new div. Otherwise cnt reloads from div.
- Stop request: the terminal-count ce still fires, then the channel enters STOPPED. Toggle is held, so phase holds its level, and cnt holds 0.
- Write landing at the terminal-count edge of a RUNNING channel: the write is applied as the reload value directly. pending is not set, and the ce at that edge still fires.
- Writes and stopped channels:
  - Only channel cfg_ch updates. Other channels are unaffected and keep counting.
  - cfg_ch >= CHANNELS: the write is ignored.
- Stopped channels: ce=0 constantly. phase=toggle^inv, and an inv write still updates it next cycle.
- Widths: cnt wraps nowhere; reload always comes from div. Maximum period is 2^DIV_W cycles.

Optional Feature:
- Macro: CLKEN_DIVBANK_ALIGN_EN.
- With the macro defined, one extra input is added: align, 1 bit.
  - At an edge with align=1, every RUNNING channel reloads cnt from its active div, clears toggle, applies any pending config and emits no ce that cycle.
  - Result: all channels restart phase-aligned, with the first ce D+1 edges later.
  - align has lower priority than rst and higher priority than cfg_we to the same channel; that write is then treated as written to a running channel.
- Without the macro, the port does not exist and channels are never realigned.

Test Plan:
- Reset then write ch0 with D=3, run=1 -> ce[0] high 1 cycle out of every 4, first pulse 4 edges after the write. phase[0] period is 8 cycles. Other ce stay 0.
- ch1 running at D=1, write D=4 mid-count -> pend[1]=1 until the next ce[1]. That pulse spacing stays 2; spacing then becomes 5, and pend[1] returns to 0.
- ch2 running at D=2, write run=0 -> one more ce[2] at terminal count, then ce[2]=0 forever. phase[2] is frozen. A write of inv=1 flips phase[2] the next cycle.
- Write exactly on ch3's terminal-count edge with D=0 -> ce[3] fires at that edge, then every cycle. pend[3] never asserts.
- Assert rst for 1 cycle while all 4 channels run -> next cycle ce=0, phase=0 and pend=0. No pulses appear until the channels are reconfigured.
- With CLKEN_DIVBANK_ALIGN_EN, run ch0 at D=2 and ch1 at D=5 out of phase, pulse align -> no ce on the align cycle. The ce[0] and ce[1] pulses then coincide every 6 cycles.
